inverter_test_sequencer: RTL

Synchronous stimulus-and-check controller for the switch-level inverter cell. It drives the inverter input with a square wave of programmable half-period and toggle count, samples the inverter output a fixed settle time after each edge, and counts mismatches against the expected complement. It replaces free-running `initial`/`forever` stimulus with a clocked sequencer that can be started, aborted and reused inside larger self-checking benches or on-chip test logic.

---
 rtl/inverter_test_sequencer_if.sv | 20 ++
 rtl/inverter_test_sequencer.sv | 112 +++++++++++
 2 files changed

// File: rtl/inverter_test_sequencer_if.sv
// inverter_test_sequencer_if: control, status and inverter pins of the test sequencer
interface inverter_test_sequencer_if;
    logic       start;
    logic       abort;
    logic       inv_in;
    logic       inv_out;
    logic       busy;
    logic       done;
    logic       pass;
    logic [7:0] err_count;
    logic [7:0] toggle_count;
    modport master (
        output start, abort, inv_out,
        input  inv_in, busy, done, pass, err_count, toggle_count
    );
    modport slave (
        input  start, abort, inv_out,
        output inv_in, busy, done, pass, err_count, toggle_count
    );
endinterface

// File: rtl/inverter_test_sequencer.sv
// inverter_test_sequencer: square-wave stimulus and settle-time check of an inverter cell
module inverter_test_sequencer #(
    parameter int HALF_PERIOD = 20,
    parameter int NUM_TOGGLES = 15,
    parameter int SETTLE      = 2
) (
    input logic                      clk,
    input logic                      rst_n,
    inverter_test_sequencer_if.slave bus
);
    localparam int TW = $clog2(HALF_PERIOD);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    state_t        state_q, state_d;
    logic [TW-1:0] tmr_q, tmr_d;
    logic [TW:0]   tmr_inc;
    logic          inv_in_q, inv_in_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic          pass_q, pass_d;
    logic [7:0]    err_count_q, err_count_d;
    logic [7:0]    toggle_count_q, toggle_count_d;
    logic          sample, phase_end, more;
    assign bus.inv_in       = inv_in_q;
    assign bus.busy         = busy_q;
    assign bus.done         = done_q;
    assign bus.pass         = pass_q;
    assign bus.err_count    = err_count_q;
    assign bus.toggle_count = toggle_count_q;
    // next-state: the sample fires on the edge where the incremented timer reaches SETTLE
    always_comb begin
        tmr_inc        = {1'b0, tmr_q} + (TW+1)'(1);
        sample         = tmr_inc == (TW+1)'(SETTLE);
        phase_end      = tmr_q == TW'(HALF_PERIOD - 1);
        more           = toggle_count_q < 8'(NUM_TOGGLES);
        state_d        = state_q;
        tmr_d          = tmr_q;
        inv_in_d       = inv_in_q;
        busy_d         = busy_q;
        done_d         = 1'b0;
        pass_d         = pass_q;
        err_count_d    = err_count_q;
        toggle_count_d = toggle_count_q;
        case (state_q)
            IDLE: begin
                if (bus.start && !bus.abort) begin
                    state_d        = RUN;
                    busy_d         = 1'b1;
                    inv_in_d       = 1'b0;
                    tmr_d          = '0;
                    err_count_d    = '0;
                    toggle_count_d = '0;
                    pass_d         = 1'b0;
                end
            end
            RUN: begin
                if (bus.abort) begin
                    state_d  = IDLE;
                    busy_d   = 1'b0;
                    inv_in_d = 1'b0;
                end else begin
                    tmr_d = tmr_inc[TW-1:0];
                    if (sample && bus.inv_out == inv_in_q)
                        err_count_d = err_count_q == 8'hFF ? err_count_q : err_count_q + 8'd1;
                    if (phase_end) begin
                        tmr_d = '0;
                        if (more) begin
                            inv_in_d       = ~inv_in_q;
                            toggle_count_d = toggle_count_q + 8'd1;
                        end else begin
                            state_d = DONE;
                            busy_d  = 1'b0;
                            done_d  = 1'b1;
                            pass_d  = err_count_q == 8'd0;
                        end
                    end
                end
            end
            DONE: begin
                state_d  = IDLE;
                inv_in_d = 1'b0;
                pass_d   = bus.abort ? 1'b0 : pass_q;
            end
            default: begin
                state_d  = IDLE;
                busy_d   = 1'b0;
                inv_in_d = 1'b0;
            end
        endcase
    end
    // state and registered outputs, asynchronously cleared
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= IDLE;
            tmr_q          <= '0;
            inv_in_q       <= 1'b0;
            busy_q         <= 1'b0;
            done_q         <= 1'b0;
            pass_q         <= 1'b0;
            err_count_q    <= '0;
            toggle_count_q <= '0;
        end else begin
            state_q        <= state_d;
            tmr_q          <= tmr_d;
            inv_in_q       <= inv_in_d;
            busy_q         <= busy_d;
            done_q         <= done_d;
            pass_q         <= pass_d;
            err_count_q    <= err_count_d;
            toggle_count_q <= toggle_count_d;
        end
    end
endmodule
